// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART packet decoder: FSM state encoding,
// error codes and the default start-of-packet byte.
package uart_pkt_pkg;

  // State encoding; the decoder's state register is 3 bits wide.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CMD     = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_CMD     = ST_CMD,
    S_LEN     = ST_LEN,
    S_PAYLOAD = ST_PAYLOAD,
    S_CSUM    = ST_CSUM
  } state_t;

  // Reason codes reported on err_code.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TO   = 2'b11;

  // Start-of-packet byte used when the instantiator does not override it.
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload storage: a shadow array filled byte by byte while a packet is
// being received, and an output array that takes a parallel copy of the
// shadow only when a packet is committed. Reads are combinational.
module uart_pkt_buf
  import uart_pkt_pkg::*;
#(
  parameter int MAX_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic       commit,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] shadow_mem [MAX_LEN];
  logic [7:0] out_mem    [MAX_LEN];

  // Shadow array: capture incoming payload bytes at their index.
  // NOTE: both arrays are reset because rd_data must read as zero before the
  // first good packet; that makes them flops, not an inferable RAM.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) shadow_mem[i] <= 8'h00;
    end else begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (wr_en && wr_addr == 4'(i)) shadow_mem[i] <= wr_data;
      end
    end
  end

  // Output array: parallel copy of the shadow on commit, otherwise held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < MAX_LEN; i++) out_mem[i] <= 8'h00;
    end else if (commit) begin
      for (int i = 0; i < MAX_LEN; i++) out_mem[i] <= shadow_mem[i];
    end
  end

  // Read port: out-of-range addresses return zero.
  always_comb begin
    // NOTE: rd_data gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    rd_data = 8'h00;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (rd_addr == 4'(i)) rd_data = out_mem[i];
    end
  end

endmodule

// File: rtl/uart_pkt_rx.sv
// Packet decoder downstream of the UART receiver. Frames the byte stream
// as SYNC, CMD, LEN, PAYLOAD[LEN], CSUM, checks an XOR checksum over
// CMD/LEN/PAYLOAD, and publishes good packets to the game-control logic.
// Length, checksum and inter-byte timeout failures pulse err_tick.
module uart_pkt_rx
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN = 8,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int         TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_done_tick,
  input  logic [7:0] din,
  output logic       pkt_valid,
  output logic [7:0] pkt_cmd,
  output logic [3:0] pkt_len,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       err_tick,
  output logic [1:0] err_code
);

  localparam int               CNT_W     = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  state_t           state, state_nxt;
  logic [7:0]       cmd_sh, cmd_nxt;
  logic [3:0]       len_sh, len_nxt;
  logic [3:0]       n, n_nxt;
  logic [7:0]       x, x_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             valid_nxt, err_tick_nxt;
  logic [1:0]       err_code_nxt;
  logic [7:0]       pkt_cmd_nxt;
  logic [3:0]       pkt_len_nxt;
  logic             buf_wr, buf_commit;
  logic             timeout;

  uart_pkt_buf #(.MAX_LEN(MAX_LEN)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (buf_wr),
    .wr_addr (n),
    .wr_data (din),
    .commit  (buf_commit),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // Register block: all decoder state and the registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cmd_sh    <= 8'h00;
      len_sh    <= 4'h0;
      n         <= 4'h0;
      x         <= 8'h00;
      cnt       <= '0;
      pkt_valid <= 1'b0;
      err_tick  <= 1'b0;
      err_code  <= ERR_NONE;
      pkt_cmd   <= 8'h00;
      pkt_len   <= 4'h0;
    end else begin
      state     <= state_nxt;
      cmd_sh    <= cmd_nxt;
      len_sh    <= len_nxt;
      n         <= n_nxt;
      x         <= x_nxt;
      cnt       <= cnt_nxt;
      pkt_valid <= valid_nxt;
      err_tick  <= err_tick_nxt;
      err_code  <= err_code_nxt;
      pkt_cmd   <= pkt_cmd_nxt;
      pkt_len   <= pkt_len_nxt;
    end
  end

  // Next-state block: byte-driven framing plus the inter-byte timeout.
  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_sh;
    len_nxt      = len_sh;
    n_nxt        = n;
    x_nxt        = x;
    cnt_nxt      = cnt;
    valid_nxt    = 1'b0;
    err_tick_nxt = 1'b0;
    err_code_nxt = err_code;
    pkt_cmd_nxt  = pkt_cmd;
    pkt_len_nxt  = pkt_len;
    buf_wr       = 1'b0;
    buf_commit   = 1'b0;

    // A byte arriving in the expiry cycle wins over the timeout.
    timeout = (state != S_IDLE) && !rx_done_tick && (cnt == CNT_LAST);

    if (state != S_IDLE) begin
      cnt_nxt = rx_done_tick ? '0 : cnt + CNT_W'(1);
    end

    case (state)
      S_IDLE: begin
        if (rx_done_tick && din == SYNC) begin
          state_nxt = S_CMD;
          cnt_nxt   = '0;
        end
      end
      S_CMD: begin
        if (rx_done_tick) begin
          cmd_nxt   = din;
          x_nxt     = din;
          state_nxt = S_LEN;
        end
      end
      S_LEN: begin
        if (rx_done_tick) begin
          x_nxt   = x ^ din;
          len_nxt = din[3:0];
          if (din > MAX_LEN_B) begin
            err_tick_nxt = 1'b1;
            err_code_nxt = ERR_LEN;
            state_nxt    = S_IDLE;
          end else if (din == 8'h00) begin
            state_nxt = S_CSUM;
          end else begin
            n_nxt     = 4'h0;
            state_nxt = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (rx_done_tick) begin
          buf_wr = 1'b1;
          x_nxt  = x ^ din;
          if (n == len_sh - 4'd1) state_nxt = S_CSUM;
          else                    n_nxt     = n + 4'd1;
        end
      end
      S_CSUM: begin
        if (rx_done_tick) begin
          if (din == x) begin
            buf_commit  = 1'b1;
            pkt_cmd_nxt = cmd_sh;
            pkt_len_nxt = len_sh;
            valid_nxt   = 1'b1;
          end else begin
            err_tick_nxt = 1'b1;
            err_code_nxt = ERR_CSUM;
          end
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (timeout) begin
      state_nxt    = S_IDLE;
      cnt_nxt      = '0;
      err_tick_nxt = 1'b1;
      err_code_nxt = ERR_TO;
    end
  end

endmodule
